stream_fifo: RTL and testbench
==============================

STREAM_FIFO -- requirements
Module: stream_fifo

Interface
REQ-001 The block SHALL take parameter DATA_WIDTH, default 32, the payload width of the data/valid/ready stream.
REQ-002 The block SHALL take parameter DEPTH, default 4, the number of entries; legal values are powers of two >= 2.
REQ-003 The block SHALL have one clock; reset SHALL be asynchronous and active-low.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 in_data  input  DATA_WIDTH  upstream payload.
REQ-007 in_valid  input  1  upstream payload valid.
REQ-008 in_ready  output  1  block can accept a word this cycle.
REQ-009 out_data  output  DATA_WIDTH  payload presented to the downstream consumer.
REQ-010 out_valid  output  1  out_data holds a valid word.
REQ-011 out_ready  input  1  downstream accepts out_data this cycle.
REQ-012 count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-013 full  output  1  count == DEPTH.
REQ-014 empty  output  1  count == 0.

Function
REQ-015 Push SHALL occur on a rising edge where in_valid && in_ready; pop SHALL occur on a rising edge where out_valid && out_ready.
REQ-016 in_ready SHALL equal !full and SHALL be a function of registered state only (no combinational path from out_ready or in_valid).
REQ-017 out_valid SHALL equal !empty; out_data SHALL equal the entry at the read pointer (oldest word), driven from storage with no path from in_data.
REQ-018 Latency: a word pushed at edge N SHALL first be visible on out_data/out_valid after edge N (earliest pop at edge N+1); no fall-through.
REQ-019 Words SHALL leave in exactly the order accepted; no word SHALL be dropped or duplicated.
REQ-020 Write and read pointers SHALL be $clog2(DEPTH) bits and wrap from DEPTH-1 to 0.
REQ-021 count SHALL update per edge: push only +1, pop only -1, both or neither unchanged.
REQ-022 Simultaneous push and pop with 0 < count < DEPTH SHALL keep count unchanged and advance both pointers.
REQ-023 When full, in_ready SHALL be 0 and no push SHALL occur, even if a pop occurs the same edge; in_ready rises the cycle after the pop.
REQ-024 When empty, out_valid SHALL be 0 and out_ready SHALL have no effect; a push on an empty block SHALL NOT be popped on the same edge.
REQ-025 out_data while out_valid == 0 SHALL be don't-care; storage entries SHALL NOT be reset.
REQ-026 in_data SHALL be sampled only on a push edge; changes to in_data while in_ready == 0 SHALL have no effect.

Reset
REQ-027 While rst_n == 0: pointers = 0, count = 0, empty = 1, full = 0, out_valid = 0, in_ready = 1, asynchronously to clk.
REQ-028 Reset asserted mid-operation SHALL discard all stored words; after release the first popped word SHALL be the first word pushed post-reset.
REQ-029 The first push SHALL be possible on the first rising edge after rst_n deasserts.

Verification
REQ-030 Reset then in_valid=1, in_data=32'hA5A5_0001, out_ready=0 for one edge -> count=1, out_valid=1, out_data=32'hA5A5_0001; out_valid was 0 before that edge.
REQ-031 Push 0x1..0x4 with out_ready=0 -> after 4th edge full=1, in_ready=0, count=4; a 5th word 0x5 held with in_valid=1 is not accepted while full.
REQ-032 Full (0x1..0x4), out_ready=1 and in_valid=1 with 0x5 for one edge -> 0x1 popped, 0x5 not accepted, count=3, in_ready=1 next cycle.
REQ-033 count=2, in_valid=out_ready=1 for 10 edges with incrementing data -> count stays 2, output sequence in order, pointers wrap at least twice.
REQ-034 Empty, out_ready=1, push 0x7 -> out_valid=0 before the edge, 0x7 popped at the following edge, count returns 0, empty=1.
REQ-035 count=3, assert rst_n=0 between edges -> count=0, out_valid=0, in_ready=1 immediately; after release push 0x9 then pop -> out_data=0x9.

Source files
------------

// File: rtl/stream_fifo.sv
// Synchronous ready/valid FIFO with registered flow-control outputs and no fall-through.
// Occupancy is tracked in an explicit counter so full/empty never depend on pointer compares.
module stream_fifo #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DATA_WIDTH-1:0]    in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]       count_q, count_d;
    logic                  push, pop;

    // Flow control depends only on the occupancy register.
    assign full      = (count_q == CntW'(DEPTH));
    assign empty     = (count_q == '0);
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign out_data  = mem_q[rd_ptr_q];
    assign count     = count_q;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is intentionally left unreset; contents are only observed behind out_valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

endmodule

// File: tb/tb_stream_fifo.sv
// Directed bench for stream_fifo: stimulus queues expected words, a negedge monitor checks pops.
module tb_stream_fifo;

    logic        clk;
    logic        rst_n;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  count;
    logic        full;
    logic        empty;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    logic [31:0] exp_q [$];

    stream_fifo #(
        .DATA_WIDTH(32),
        .DEPTH     (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .count    (count),
        .full     (full),
        .empty    (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Inputs change 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // A handshake seen at the negedge completes on the next rising edge.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL pop_unexpected: got 0x%0h, expected no word", out_data);
            end else begin
                chk("pop_order", out_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        #1;
        step();
        step();
        chk("rst_count",     32'(count), 32'd0);
        chk("rst_empty",     32'(empty), 32'd1);
        chk("rst_full",      32'(full), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready",  32'(in_ready), 32'd1);
        rst_n = 1'b1;

        // First word on the first edge after reset release.
        in_valid = 1'b1;
        in_data  = 32'hA5A5_0001;
        exp_q.push_back(32'hA5A5_0001);
        chk("first_ov_before", 32'(out_valid), 32'd0);
        step();
        in_valid = 1'b0;
        chk("first_count",    32'(count), 32'd1);
        chk("first_ov_after", 32'(out_valid), 32'd1);
        chk("first_data",     out_data, 32'hA5A5_0001);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("first_drained", 32'(empty), 32'd1);

        // Fill to full; a fifth word is refused.
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1;
            in_data  = 32'(i);
            exp_q.push_back(32'(i));
            step();
        end
        chk("fill_full",     32'(full), 32'd1);
        chk("fill_in_ready", 32'(in_ready), 32'd0);
        chk("fill_count",    32'(count), 32'd4);
        in_data = 32'h5;
        step();
        step();
        chk("full_hold_count", 32'(count), 32'd4);

        // Pop while full: push of 0x5 must still be refused.
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("full_pop_count",    32'(count), 32'd3);
        chk("full_pop_in_ready", 32'(in_ready), 32'd1);
        chk("full_pop_full",     32'(full), 32'd0);

        // Drop to two entries, then stream 10 words through with both sides active.
        out_ready = 1'b1;
        step();
        chk("stream_pre_count", 32'(count), 32'd2);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data  = 32'h10 + 32'(i);
            exp_q.push_back(32'h10 + 32'(i));
            step();
            chk("stream_count", 32'(count), 32'd2);
        end
        in_valid = 1'b0;
        step();
        step();
        out_ready = 1'b0;
        chk("stream_drained", 32'(empty), 32'd1);

        // Push into an empty FIFO with out_ready high: no same-edge pop.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'h7;
        exp_q.push_back(32'h7);
        chk("empty_ov_before", 32'(out_valid), 32'd0);
        step();
        in_valid = 1'b0;
        chk("empty_push_count", 32'(count), 32'd1);
        chk("empty_push_ov",    32'(out_valid), 32'd1);
        step();
        out_ready = 1'b0;
        chk("empty_pop_count", 32'(count), 32'd0);
        chk("empty_pop_empty", 32'(empty), 32'd1);

        // Mid-operation asynchronous reset discards stored words.
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 32'hA + 32'(i);
            step();
        end
        in_valid = 1'b0;
        chk("pre_rst_count", 32'(count), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_count",    32'(count), 32'd0);
        chk("async_rst_ov",       32'(out_valid), 32'd0);
        chk("async_rst_in_ready", 32'(in_ready), 32'd1);
        chk("async_rst_empty",    32'(empty), 32'd1);
        step();
        rst_n = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'h9;
        exp_q.push_back(32'h9);
        step();
        in_valid = 1'b0;
        chk("post_rst_data", out_data, 32'h9);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("post_rst_empty", 32'(empty), 32'd1);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
